// File: rtl/code_loader.sv
// code_loader: receives a byte stream and writes it into a code memory as 32-bit words.
// Stream layout: 4-byte big-endian word count N, then N big-endian words, then
// (only when LOADER_CHECKSUM_EN is defined) one XOR checksum byte over the data bytes.
// Optional feature macro: LOADER_CHECKSUM_EN (undefined by default: no CSUM state).
module code_loader #(
  parameter int unsigned CODE_SIZE = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        we,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Largest accepted word count; 33 bits so CODE_SIZE+1 cannot overflow.
  localparam logic [32:0] MAX_WORDS = 33'(CODE_SIZE) + 33'd1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;   // byte position within the current 32-bit field
  logic [23:0] shift_q, shift_d;         // first three bytes of the field being assembled
  logic [31:0] len_q, len_d;             // word count N
  logic [31:0] word_idx_q, word_idx_d;   // index k of the next word to write
  logic        we_q, we_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] assembled;                // current field completed with this cycle's byte
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;           // running XOR of all DATA bytes
`endif

  // State and datapath registers; reset forces every register to its idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state logic: byte assembly, length check, word writes and checksum compare.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    assembled  = {shift_q, rx_data};

    case (state_q)
      // Not busy: only start matters; a byte arriving with start is dropped.
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          byte_cnt_d = '0;
          shift_d    = '0;
          len_d      = '0;
          word_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      ST_LEN: begin
        if (rx_valid) begin
          shift_d    = assembled[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (assembled == '0) begin
              state_d = ST_DONE;
            end else if ({1'b0, assembled} > MAX_WORDS) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_DATA;
              len_d   = assembled;
            end
          end
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          shift_d    = assembled[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            w_addr_d   = word_idx_q;
            w_data_d   = assembled;
            word_idx_d = word_idx_q + 32'd1;
            if (word_idx_q == len_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: status flags follow the state register directly.
  always_comb begin
    we     = we_q;
    w_addr = w_addr_q;
    w_data = w_data_q;
    done   = (state_q == ST_DONE);
    err    = (state_q == ST_ERR);
`ifdef LOADER_CHECKSUM_EN
    busy   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    busy   = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader (CODE_SIZE = 32767).
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int we_base  = 0;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] cs;
`endif

  code_loader #(.CODE_SIZE(32767)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .we       (we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count write pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start;
    rx_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",     {31'd0, we},   32'd0);
    chk("rst_addr",   w_addr,        32'd0);
    chk("rst_data",   w_data,        32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_err",    {31'd0, err},  32'd0);
    rst = 1'b0;
    idle(1);
    chk("idle_ignores_rx_busy", {31'd0, busy}, 32'd0);

    // Two-word load, bytes back to back.
    pulse_start();
    chk("a_busy_after_start", {31'd0, busy}, 32'd1);
    we_base = we_cnt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    chk("a_len_busy", {31'd0, busy}, 32'd1);
    chk("a_len_no_we", {31'd0, we}, 32'd0);
    send(8'hDE); send(8'hAD); send(8'hBE);
    chk("a_w0_not_early", {31'd0, we}, 32'd0);
    send(8'hEF);
    chk("a_w0_we",   {31'd0, we}, 32'd1);
    chk("a_w0_addr", w_addr, 32'd0);
    chk("a_w0_data", w_data, 32'hDEADBEEF);
    send(8'h01);
    chk("a_we_one_cycle", {31'd0, we}, 32'd0);
    chk("a_addr_hold", w_addr, 32'd0);
    send(8'h02); send(8'h03); send(8'h04);
    chk("a_w1_we",   {31'd0, we}, 32'd1);
    chk("a_w1_addr", w_addr, 32'd1);
    chk("a_w1_data", w_data, 32'h01020304);
`ifdef LOADER_CHECKSUM_EN
    chk("a_csum_busy", {31'd0, busy}, 32'd1);
    cs = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04;
    send(cs);
`endif
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_err",  {31'd0, err},  32'd0);
    chk("a_idle", {31'd0, busy}, 32'd0);
    idle(1);
    chk("a_we_low",    {31'd0, we}, 32'd0);
    chk("a_addr_keep", w_addr, 32'd1);
    chk("a_data_keep", w_data, 32'h01020304);
    chk("a_done_stick", {31'd0, done}, 32'd1);
    chk("a_we_count", we_cnt - we_base, 2);

    // Start together with a byte: byte dropped; zero length finishes at once.
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b_done_cleared", {31'd0, done}, 32'd0);
    chk("b_busy", {31'd0, busy}, 32'd1);
    we_base = we_cnt;
    send(8'h00); send(8'h00); send(8'h00);
    chk("b_len3_busy", {31'd0, busy}, 32'd1);
    chk("b_len3_err",  {31'd0, err},  32'd0);
    send(8'h00);
    chk("b_zero_done", {31'd0, done}, 32'd1);
    chk("b_zero_busy", {31'd0, busy}, 32'd0);
    idle(2);
    chk("b_no_we", we_cnt - we_base, 0);

    // Length one past capacity.
    pulse_start();
    chk("c_done_cleared", {31'd0, done}, 32'd0);
    we_base = we_cnt;
    send(8'h00); send(8'h00); send(8'h80); send(8'h01);
    chk("c_err",  {31'd0, err},  32'd1);
    chk("c_busy", {31'd0, busy}, 32'd0);
    chk("c_done", {31'd0, done}, 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    chk("c_err_stick", {31'd0, err}, 32'd1);
    chk("c_no_we", we_cnt - we_base, 0);

    // Length exactly at capacity is accepted; reset mid-word drops the load.
    pulse_start();
    chk("d_err_cleared", {31'd0, err}, 32'd0);
    send(8'h00); send(8'h00); send(8'h80); send(8'h00);
    chk("d_max_len_busy", {31'd0, busy}, 32'd1);
    chk("d_max_len_err",  {31'd0, err},  32'd0);
    we_base = we_cnt;
    send(8'hAA); send(8'hBB);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("d_rst_busy", {31'd0, busy}, 32'd0);
    chk("d_rst_addr", w_addr, 32'd0);
    chk("d_rst_data", w_data, 32'd0);
    chk("d_rst_we",   {31'd0, we}, 32'd0);
    chk("d_rst_done", {31'd0, done}, 32'd0);
    chk("d_rst_err",  {31'd0, err},  32'd0);
    send(8'hCC); send(8'hDD);
    rx_valid = 1'b0;
    rst = 1'b0;
    idle(1);
    chk("d_no_we", we_cnt - we_base, 0);
    chk("d_idle_busy", {31'd0, busy}, 32'd0);

    // Fresh load after reset; a start during the load is ignored.
    pulse_start();
    we_base = we_cnt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    send(8'hCA);
    start = 1'b1;
    send(8'hFE);
    start = 1'b0;
    send(8'hF0); send(8'h0D);
    chk("e_w0_addr", w_addr, 32'd0);
    chk("e_w0_data", w_data, 32'hCAFEF00D);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("e_w1_addr", w_addr, 32'd1);
    chk("e_w1_data", w_data, 32'h12345678);
`ifdef LOADER_CHECKSUM_EN
    cs = 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
    send(cs);
`endif
    chk("e_done", {31'd0, done}, 32'd1);
    idle(1);
    chk("e_we_count", we_cnt - we_base, 2);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: both words still written, then error.
    pulse_start();
    we_base = we_cnt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h00);
    chk("f_err",  {31'd0, err},  32'd1);
    chk("f_done", {31'd0, done}, 32'd0);
    idle(1);
    chk("f_we_count", we_cnt - we_base, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
